// File: rtl/csr_access_unit.sv
// Zicsr sequencer: read the addressed CSR, optionally issue one write strobe, return the old value.
// Optional macro CSR_RO_TRAP_EN: writes to the read-only space (addr[11:10]=11) trap instead of being dropped.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_val,
  input  logic [4:0]        req_zimm,
  input  logic              req_rs1_x0,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_illegal,
  output logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  input  logic              csr_hit,
  output logic              csr_en_rw,
  output logic [1:0]        csr_rw_mode,
  output logic [XLEN-1:0]   csr_d
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [1:0]        kind_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   src_q;
  logic              wr_needed_q;
  logic [1:0]        mode_q;
  logic [XLEN-1:0]   d_q;
  logic [XLEN-1:0]   rdata_q;
  logic              illegal_q;

  logic              accept;
  logic              wr_needed_d;
  logic [XLEN-1:0]   src_d;
  logic              bad_f3, ro_space, illegal, do_write;

  assign accept = (state_q == IDLE) && req_valid;

  // funct3[1:0]=01 is RW/RWI; set/clear forms only write with a nonzero source field.
  assign wr_needed_d = (req_funct3[1:0] == 2'b01) ||
                       (req_funct3[2] ? (req_zimm != 5'd0) : !req_rs1_x0);
  assign src_d       = req_funct3[2] ? {{(XLEN-5){1'b0}}, req_zimm} : req_rs1_val;

  assign bad_f3   = (kind_q == 2'b00);
  assign ro_space = (addr_q[ADDR_W-1 -: 2] == 2'b11);

`ifdef CSR_RO_TRAP_EN
  assign illegal  = bad_f3 || !csr_hit || (wr_needed_q && ro_space);
  assign do_write = !illegal && wr_needed_q;
`else
  // Writes into read-only space are dropped quietly; the read still completes.
  assign illegal  = bad_f3 || !csr_hit;
  assign do_write = !illegal && wr_needed_q && !ro_space;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kind_q      <= 2'b00;
      addr_q      <= '0;
      src_q       <= '0;
      wr_needed_q <= 1'b0;
      mode_q      <= 2'b00;
      d_q         <= '0;
      rdata_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      if (accept) begin
        kind_q      <= req_funct3[1:0];
        addr_q      <= req_addr;
        src_q       <= src_d;
        wr_needed_q <= wr_needed_d;
      end
      if (state_q == READ) begin
        rdata_q   <= illegal ? '0 : csr_rdata;
        illegal_q <= illegal;
        mode_q    <= kind_q;
        // Consumer clears with q&d, so the clear mask is sent inverted.
        d_q       <= (kind_q == 2'b11) ? ~src_q : src_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = READ;
      READ:    state_d = do_write ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    csr_en_rw   = 1'b0;
    csr_rw_mode = 2'b00;
    csr_d       = '0;
    unique case (state_q)
      IDLE:  req_ready = 1'b1;
      WRITE: begin
        csr_en_rw   = 1'b1;
        csr_rw_mode = mode_q;
        csr_d       = d_q;
      end
      RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign csr_addr    = addr_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a 16-entry CSR file, a per-cycle compare process, directed and random ops.
module tb_csr_access_unit;
  localparam int XLEN = 32, ADDR_W = 12;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, req_rs1_x0;
  logic [2:0] req_funct3;
  logic [ADDR_W-1:0] req_addr, csr_addr;
  logic [XLEN-1:0] req_rs1_val, rsp_rdata, csr_rdata, csr_d;
  logic [4:0] req_zimm;
  logic rsp_valid, rsp_ready, rsp_illegal, csr_hit, csr_en_rw;
  logic [1:0] csr_rw_mode;

  always #5 clk = ~clk;

  csr_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_rs1_val(req_rs1_val), .req_zimm(req_zimm), .req_rs1_x0(req_rs1_x0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
    .csr_en_rw(csr_en_rw), .csr_rw_mode(csr_rw_mode), .csr_d(csr_d));

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // CSR file seen by the DUT: 16 entries hashed from the address, index 15 unimplemented.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic miss_force = 1'b0;
  function automatic logic [3:0] idx(input logic [11:0] a);
    return a[3:0] ^ a[11:8];
  endfunction
  function automatic logic hit_of(input logic [11:0] a, input logic mf);
    return !mf && (idx(a) != 4'hF);
  endfunction
  assign csr_rdata = mem[idx(csr_addr)];
  assign csr_hit   = hit_of(csr_addr, miss_force);

  logic pl_go = 1'b0;
  logic [3:0] pl_idx = '0;
  logic [31:0] pl_val = '0;

  // Write port: sample strobe mid-cycle, apply at the clock edge like the real counter block.
  logic wr_s = 1'b0;
  logic [1:0] mode_s = '0;
  logic [31:0] d_s = '0;
  logic [3:0] idx_s = '0;
  always @(negedge clk) begin
    wr_s = csr_en_rw; mode_s = csr_rw_mode; d_s = csr_d; idx_s = idx(csr_addr);
  end
  always @(posedge clk) begin
    if (pl_go) mem[pl_idx] = pl_val;
    else if (wr_s && !reset) begin
      case (mode_s)
        2'b01:   mem[idx_s] = d_s;
        2'b10:   mem[idx_s] = mem[idx_s] | d_s;
        2'b11:   mem[idx_s] = mem[idx_s] & d_s;
        default: ;
      endcase
    end
  end

  logic rdy_rand = 1'b0, rdy_force = 1'b1;
  initial rsp_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    rsp_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_force;
  end

  // Reference model and per-cycle compare.
  logic busy = 1'b0, seen_rsp = 1'b0;
  int cnt = 0, strobes = 0, lat_seen = 0, n_rsp = 0;
  logic e_strobe, e_ill;
  logic [1:0] e_mode;
  logic [31:0] e_d, e_rdata, e_new;
  logic [3:0] e_idx;
  int e_lat;
  logic [31:0] last_rdata, last_d, cur_d;
  logic [1:0] last_mode, cur_mode;
  logic last_ill;
  int last_strobes, last_lat;
  logic exp_en;

  always @(negedge clk) begin
    logic [1:0] kind; logic imm, wr, ro, h; logic [31:0] src, old;
    if (pl_go) ref_mem[pl_idx] = pl_val;
    if (reset) begin
      busy = 1'b0;
    end else if (busy) begin
      cnt++;
      exp_en = e_strobe && (cnt == 2);
      chk("csr_en_rw", 32'(csr_en_rw), 32'(exp_en));
      chk("csr_rw_mode", 32'(csr_rw_mode), exp_en ? 32'(e_mode) : 32'd0);
      chk("csr_d", csr_d, exp_en ? e_d : 32'd0);
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("rsp_valid", 32'(rsp_valid), 32'(cnt > e_lat));
      if (csr_en_rw) begin strobes++; cur_mode = csr_rw_mode; cur_d = csr_d; end
      if (rsp_valid) begin
        if (!seen_rsp) begin seen_rsp = 1'b1; lat_seen = cnt - 1; end
        chk("rsp_rdata", rsp_rdata, e_rdata);
        chk("rsp_illegal", 32'(rsp_illegal), 32'(e_ill));
        if (rsp_ready) begin
          if (e_strobe) ref_mem[e_idx] = e_new;
          last_rdata = rsp_rdata; last_ill = rsp_illegal; last_strobes = strobes;
          last_mode = cur_mode; last_d = cur_d; last_lat = lat_seen;
          busy = 1'b0; n_rsp++;
        end
      end else if (cnt > 30) begin
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
        busy = 1'b0;
      end
    end else begin
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      chk("csr_en_idle", 32'(csr_en_rw), 32'd0);
      if (req_valid && req_ready) begin
        kind = req_funct3[1:0]; imm = req_funct3[2];
        src  = imm ? {27'd0, req_zimm} : req_rs1_val;
        wr   = (kind == 2'b01) || (imm ? (req_zimm != 5'd0) : !req_rs1_x0);
        ro   = (req_addr[11:10] == 2'b11);
        h    = hit_of(req_addr, miss_force);
        e_idx = idx(req_addr);
        old  = ref_mem[e_idx];
`ifdef CSR_RO_TRAP_EN
        e_ill = (kind == 2'b00) || !h || (wr && ro);
`else
        e_ill = (kind == 2'b00) || !h;
`endif
        e_strobe = !e_ill && wr && !ro;
        e_rdata  = e_ill ? 32'd0 : old;
        case (kind)
          2'b01:   e_new = src;
          2'b10:   e_new = old | src;
          2'b11:   e_new = old & ~src;
          default: e_new = old;
        endcase
        e_mode = kind;
        e_d    = (kind == 2'b11) ? ~src : src;
        e_lat  = e_strobe ? 2 : 1;
        busy = 1'b1; cnt = 0; strobes = 0; seen_rsp = 1'b0;
        cur_mode = 2'b00; cur_d = 32'd0;
      end
    end
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] v);
    @(posedge clk); #1;
    pl_idx = idx(a); pl_val = v; pl_go = 1'b1;
    @(posedge clk); #1;
    pl_go = 1'b0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] z, input logic x0);
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = f3; req_addr = a; req_rs1_val = rs1; req_zimm = z; req_rs1_x0 = x0;
    t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready) chk("req_ready_wait", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    @(posedge clk); #1;
    t = 0;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (!req_ready) chk("idle_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic expect_last(input string tag, input logic [31:0] rdata, input logic ill,
                             input int nstrobe, input int lat);
    chk({tag, "_rdata"}, last_rdata, rdata);
    chk({tag, "_illegal"}, 32'(last_ill), 32'(ill));
    chk({tag, "_strobes"}, 32'(last_strobes), 32'(nstrobe));
    chk({tag, "_latency"}, 32'(last_lat), 32'(lat));
  endtask

  initial begin
    logic [31:0] snap;
    reset = 1'b1; req_valid = 1'b0; req_funct3 = '0; req_addr = '0; req_rs1_val = '0;
    req_zimm = '0; req_rs1_x0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
    chk("rst_csr_en_rw", 32'(csr_en_rw), 32'd0);
    chk("rst_csr_rw_mode", 32'(csr_rw_mode), 32'd0);
    chk("rst_csr_d", csr_d, 32'd0);
    chk("rst_csr_addr", 32'(csr_addr), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 16; i++) preload(12'(i), $urandom);
    preload(12'h340, 32'h12);
    preload(12'hC00, 32'h64);

    issue(3'b001, 12'h340, 32'hDEADBEEF, 5'd0, 1'b0); wait_idle();
    expect_last("csrrw", 32'h12, 1'b0, 1, 2);
    chk("csrrw_mode", 32'(last_mode), 32'd1);
    chk("csrrw_d", last_d, 32'hDEADBEEF);

    issue(3'b011, 12'h340, 32'h0000000F, 5'd0, 1'b0); wait_idle();
    expect_last("csrrc", 32'hDEADBEEF, 1'b0, 1, 2);
    chk("csrrc_mode", 32'(last_mode), 32'd3);
    chk("csrrc_d", last_d, 32'hFFFFFFF0);

    issue(3'b110, 12'h340, 32'hFFFFFFFF, 5'd5, 1'b0); wait_idle();
    expect_last("csrrsi", 32'hDEADBEE0, 1'b0, 1, 2);
    chk("csrrsi_mode", 32'(last_mode), 32'd2);
    chk("csrrsi_d", last_d, 32'h00000005);

    issue(3'b010, 12'hC00, 32'h1234, 5'd0, 1'b1); wait_idle();
    expect_last("csrrs_x0_ro", 32'h64, 1'b0, 0, 1);

    issue(3'b001, 12'hC00, 32'h55, 5'd0, 1'b0); wait_idle();
`ifdef CSR_RO_TRAP_EN
    expect_last("csrrw_ro", 32'h0, 1'b1, 0, 1);
`else
    expect_last("csrrw_ro", 32'h64, 1'b0, 0, 1);
`endif

    // Illegal funct3 with the response back-pressured for four cycles.
    rdy_force = 1'b0;
    issue(3'b000, 12'h340, 32'h1, 5'd0, 1'b0);
    for (int t = 0; t < 20 && !rsp_valid; t++) begin @(posedge clk); #1; end
    chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    snap = rsp_rdata;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("hold_valid_stable", 32'(rsp_valid), 32'd1);
      chk("hold_rdata_stable", rsp_rdata, snap);
      chk("hold_illegal", 32'(rsp_illegal), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rdy_force = 1'b1;
    wait_idle();
    expect_last("f3_000", 32'h0, 1'b1, 0, 1);

    miss_force = 1'b1;
    issue(3'b001, 12'h340, 32'h77, 5'd0, 1'b0); wait_idle();
    expect_last("miss", 32'h0, 1'b1, 0, 1);
    miss_force = 1'b0;

    // Reset landing in the strobe cycle must kill the write.
    issue(3'b001, 12'h340, 32'hA5A5A5A5, 5'd0, 1'b0);
    for (int t = 0; t < 10 && !csr_en_rw; t++) @(negedge clk);
    chk("rst_mid_strobe_seen", 32'(csr_en_rw), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_en", 32'(csr_en_rw), 32'd0);
    chk("rst_mid_mode", 32'(csr_rw_mode), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_after_req_ready", 32'(req_ready), 32'd1);
    chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
    issue(3'b010, 12'h340, 32'h0, 5'd0, 1'b1); wait_idle();
    expect_last("after_abort", 32'hDEADBEE5, 1'b0, 0, 1);

    rdy_rand = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        miss_force = ($urandom_range(0, 3) == 0);
      end
      issue(3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
            ($urandom_range(0, 3) == 0));
    end
    wait_idle();
    rdy_rand = 1'b0;
    miss_force = 1'b0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("csr_file_%0d", i), mem[i], ref_mem[i]);
    chk("responses_seen", 32'(n_rsp > 200), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
